divider_unsigned_seq: RTL and testbench
=======================================

// Module: divider_unsigned_seq
// PURPOSE
// - Iterative restoring unsigned divider for the ALU. Computes quotient and remainder of two N-bit operands.
// - Each iteration uses the structural less-than test a < b == ~carry_out(a + ~b + 1) to pick the quotient bit.
// - Multi-cycle: one quotient bit per clock, with valid/ready handshakes on both input and output.
// - Sits beside the combinational ALU; the control FSM stalls on in_ready/out_valid.
// PARAMETERS
// - N      default 32   operand, quotient and remainder width (N >= 2)
// - CNT_W  default 6    iteration counter width; must satisfy 2**CNT_W > N
// PORTS
// - clk        in   1   rising-edge clock
// - rst_n      in   1   asynchronous reset, active low
// - in_valid   in   1   dividend/divisor valid
// - in_ready   out  1   block can accept operands
// - dividend   in   N   unsigned dividend
// - divisor    in   N   unsigned divisor
// - out_valid  out  1   quotient/remainder valid
// - out_ready  in   1   consumer accepts result
// - quotient   out  N   unsigned quotient
// - remainder  out  N   unsigned remainder
// - div_zero   out  1   divisor was zero (present only with DIV_ZERO_ERR_EN)
// BEHAVIOUR
// - Reset (async, rst_n=0) gives:
//   - state=IDLE, in_ready=1, out_valid=0
//   - quotient=0, remainder=0, div_zero=0, counter=0
// - FSM states: IDLE, BUSY, DONE.
//   - IDLE: in_ready=1. in_valid&in_ready at an edge latches the operands:
//     q_sh=dividend, r=0 (N+1 bits), d=divisor, cnt=N. Next state is BUSY.
//   - BUSY: in_ready=0. Each edge runs one step:
//     - r' = {r[N-1:0], q_sh[N-1]}
//     - ge = ~lt(r', {1'b0,d}), with lt computed by (N+1)-bit add of ~d plus c_in=1
//     - r = ge ? r'-d : r'
//     - q_sh = {q_sh[N-2:0], ge}
//     - cnt = cnt-1
//     - On the edge where cnt goes 1->0, quotient/remainder are registered and the FSM enters DONE.
//   - DONE: out_valid=1; quotient and remainder are held stable.
//     - out_valid&out_ready returns the FSM to IDLE.
//     - While out_ready=0, DONE holds indefinitely.
// - Latency:
//   - out_valid rises N edges after the input handshake edge.
//   - Throughput is one result per N+2 cycles minimum.
// - in_ready is 0 in BUSY and DONE. in_valid is ignored there; operands are never captured mid-operation.
// - Outputs change only on the BUSY->DONE edge. Between results they hold the last value.
// - Divide by zero without the macro:
//   - Runs the full N cycles.
//   - Natural result is quotient = all-ones, remainder = dividend. Required, not undefined.
// - Arithmetic:
//   - Remainder path is N+1 bits wide so the shifted-in bit never overflows.
//   - Final remainder < divisor for divisor != 0.
// - rst_n asserted mid-BUSY or mid-DONE:
//   - Immediately returns to IDLE with the reset values.
//   - The in-flight result is discarded.
// CONFIGURATION
// - DIV_ZERO_ERR_EN defined:
//   - div_zero port exists.
//   - Handshake with divisor==0 skips BUSY and goes straight to DONE the next edge (latency 1).
//   - Result: quotient=all-ones, remainder=dividend, div_zero=1.
//   - div_zero clears on the next accepted operand.
// - DIV_ZERO_ERR_EN undefined:
//   - No div_zero port.
//   - Divide by zero takes N cycles with the natural result above.
// TESTING
// - 100/7:
//   - out_valid exactly 32 edges after accept
//   - quotient=14, remainder=2
// - 32'hFFFF_FFFF/1 -> quotient=32'hFFFF_FFFF, remainder=0
// - 5/9 -> quotient=0, remainder=5
// - 32'h8000_0000/32'hFFFF_FFFF -> quotient=0, remainder=32'h8000_0000 (no signed interpretation)
// - 1234/0 -> quotient=32'hFFFF_FFFF, remainder=1234
//   - With DIV_ZERO_ERR_EN: div_zero=1 and out_valid 1 edge after accept
//   - Without: out_valid after 32 edges
// - Backpressure and reset:
//   - Hold out_ready=0 for 10 cycles in DONE: outputs stable, in_ready=0, in_valid pulses ignored.
//   - Assert rst_n=0 at BUSY cycle 12: next cycle in_ready=1, out_valid=0; a following 9/3 gives 3 r 0.

Source files
------------

// File: rtl/divider_unsigned_seq.sv
// Iterative restoring unsigned divider: one quotient bit per clock, valid/ready on both sides.
// Optional macro DIV_ZERO_ERR_EN: adds the div_zero port and a one-cycle divide-by-zero bypass.
// Without it a zero divisor runs the full N steps and yields quotient=all-ones, remainder=dividend.
module divider_unsigned_seq #(
  parameter int unsigned N     = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder
`ifdef DIV_ZERO_ERR_EN
  ,
  output logic         div_zero
`endif
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     q_sh_q, q_sh_d;    // dividend shifting out, quotient shifting in
  logic [N:0]       acc_q, acc_d;      // partial remainder, one bit wider than operands
  logic [N-1:0]     div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     quo_q, quo_d;
  logic [N-1:0]     rmd_q, rmd_d;
`ifdef DIV_ZERO_ERR_EN
  logic             dz_q, dz_d;
`endif

  logic [N:0]   r_sh;
  logic [N+1:0] sub_full;
  logic         ge;
  logic [N:0]   acc_next;
  logic [N-1:0] q_next;
  logic         unused_acc_msb;

  // The top accumulator bit is never shifted further: after each step acc < divisor.
  assign unused_acc_msb = acc_q[N];

  // One restoring step: compare via carry-out of acc + ~d + 1 (carry set means no borrow, i.e. ge).
  always_comb begin
    r_sh     = {acc_q[N-1:0], q_sh_q[N-1]};
    sub_full = {1'b0, r_sh} + {1'b0, ~{1'b0, div_q}} + {{(N+1){1'b0}}, 1'b1};
    ge       = sub_full[N+1];
    acc_next = ge ? sub_full[N:0] : r_sh;
    q_next   = {q_sh_q[N-2:0], ge};
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    q_sh_d  = q_sh_q;
    acc_d   = acc_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
`ifdef DIV_ZERO_ERR_EN
    dz_d    = dz_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          q_sh_d  = dividend;
          acc_d   = '0;
          div_d   = divisor;
          cnt_d   = CNT_W'(N);
          state_d = StBusy;
`ifdef DIV_ZERO_ERR_EN
          dz_d    = 1'b0;
          if (divisor == '0) begin
            quo_d   = '1;
            rmd_d   = dividend;
            dz_d    = 1'b1;
            state_d = StDone;
          end
`endif
        end
      end
      StBusy: begin
        q_sh_d = q_next;
        acc_d  = acc_next;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          quo_d   = q_next;
          rmd_d   = acc_next[N-1:0];
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, cleared by asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      q_sh_q  <= '0;
      acc_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
`ifdef DIV_ZERO_ERR_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      q_sh_q  <= q_sh_d;
      acc_q   <= acc_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
`ifdef DIV_ZERO_ERR_EN
      dz_q    <= dz_d;
`endif
    end
  end

  // Handshake flags decode directly from the state register.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    quotient  = quo_q;
    remainder = rmd_q;
`ifdef DIV_ZERO_ERR_EN
    div_zero  = dz_q;
`endif
  end

endmodule

// File: tb/tb_divider_unsigned_seq.sv
// Scoreboard bench for divider_unsigned_seq: expected results queued at drive, compared at output.
module tb_divider_unsigned_seq;
  localparam int unsigned N = 32;
`ifdef DIV_ZERO_ERR_EN
  localparam bit ZeroEn = 1'b1;
`else
  localparam bit ZeroEn = 1'b0;
`endif

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         in_ready, out_valid;
  logic [N-1:0] quotient, remainder;
  logic         dz_obs;

  exp_t         sb[$];
  int           tests = 0;
  int           fails = 0;
  logic [N-1:0] last_q = '0;
  logic [N-1:0] last_r = '0;

  always #5 clk = ~clk;

`ifdef DIV_ZERO_ERR_EN
  logic div_zero;
  assign dz_obs = div_zero;
`else
  assign dz_obs = 1'b0;
`endif

  divider_unsigned_seq #(.N(N), .CNT_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef DIV_ZERO_ERR_EN
    ,
    .div_zero  (div_zero)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = ZeroEn;
      e.lat = ZeroEn ? 1 : N;
    end else begin
      e.q  = a / b;
      e.r  = a % b;
      e.dz = 1'b0;
      e.lat = N;
    end
    return e;
  endfunction

  // One full transaction, optionally holding the result under backpressure for `hold` cycles.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input int hold);
    exp_t e;
    int   edges;
    @(negedge clk);
    check_eq("in_ready_idle", in_ready, 1);
    check_eq("hold_quotient", quotient, last_q);
    check_eq("hold_remainder", remainder, last_r);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    sb.push_back(model(a, b));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      #1;
      if (edges == 1 && !out_valid) check_eq("in_ready_busy", in_ready, 0);
    end while (!out_valid && edges < 200);
    e = sb.pop_front();
    check_eq("out_valid_seen", out_valid, 1);
    check_eq("latency", edges, e.lat);
    check_eq("quotient", quotient, e.q);
    check_eq("remainder", remainder, e.r);
    check_eq("div_zero", dz_obs, e.dz);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      dividend = $urandom;
      divisor  = $urandom | 1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check_eq("bp_out_valid", out_valid, 1);
      check_eq("bp_in_ready", in_ready, 0);
      check_eq("bp_quotient", quotient, e.q);
      check_eq("bp_remainder", remainder, e.r);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq("out_valid_drop", out_valid, 0);
    check_eq("in_ready_back", in_ready, 1);
    last_q = e.q;
    last_r = e.r;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_quotient", quotient, 0);
    check_eq("rst_remainder", remainder, 0);
    check_eq("rst_div_zero", dz_obs, 0);
    rst_n = 1'b1;

    run_op(32'd100, 32'd7, 0);
    run_op(32'hFFFF_FFFF, 32'd1, 0);
    run_op(32'd5, 32'd9, 10);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(32'd1234, 32'd0, 0);
    run_op(32'd77, 32'd77, 0);
    for (int k = 0; k < 4; k++) begin
      logic [N-1:0] a, b;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      run_op(a, b, 0);
    end

    // Reset in the middle of BUSY discards the in-flight result.
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 32'd50;
    divisor  = 32'd7;
    sb.push_back(model(32'd50, 32'd7));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b0;
    void'(sb.pop_back());
    #1;
    check_eq("mid_rst_in_ready", in_ready, 1);
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_quotient", quotient, 0);
    check_eq("mid_rst_remainder", remainder, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    last_q = '0;
    last_r = '0;
    run_op(32'd9, 32'd3, 0);

    check_eq("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
